// File: rtl/seqdet_ctrl.sv
// Sequencing controller for the serial sequence detector: holds the pattern config,
// serialises framed words MSB-first, counts matches. Optional: SEQDET_CTRL_TIMEOUT_EN.
module seqdet_ctrl #(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 16,
    parameter int DET_LAT = 1,
    parameter int CNT_W   = 8
`ifdef SEQDET_CTRL_TIMEOUT_EN
   ,parameter int TIMEOUT = 255
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [4:0]         cfg_len,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic               start,
    input  logic [7:0]         num_words,
    input  logic               abort,
    input  logic               word_valid,
    input  logic [DATA_W-1:0]  word_data,
    output logic               word_ready,
    output logic               det_bit,
    output logic               det_en,
    output logic               det_clr,
    output logic [4:0]         det_len,
    output logic [MAX_LEN-1:0] det_pattern,
    input  logic               det_match,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done,
`ifdef SEQDET_CTRL_TIMEOUT_EN
    output logic               timeout,
`endif
    output logic               cfg_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int         BCW     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int         DLW     = $clog2(DET_LAT + 1);
    localparam logic [4:0] LEN_MAX = 5'(MAX_LEN);

    logic [2:0]        state;
    logic [DATA_W-1:0] shreg;
    logic [BCW-1:0]    bitcnt;
    logic [7:0]        words_left;
    logic [DLW-1:0]    drain_cnt;

    logic [4:0] len_in, eff_len;
    logic       last_bit, reload, accept, tmo_hit;

`ifdef SEQDET_CTRL_TIMEOUT_EN
    localparam int TMW = $clog2(TIMEOUT + 1);
    logic [TMW-1:0] tmo_cnt;
    assign tmo_hit = (state == S_FETCH) && (tmo_cnt == TMW'(TIMEOUT));
`else
    assign tmo_hit = 1'b0;
`endif

    // A config write in the same cycle as start is judged against the new length.
    assign len_in  = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
    assign eff_len = cfg_we ? len_in : det_len;

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign det_en   = (state == S_SHIFT);
    assign det_bit  = det_en & shreg[DATA_W-1];
    assign last_bit = det_en && (bitcnt == BCW'(DATA_W - 1));
    assign reload   = last_bit && (words_left > 8'd1);

    assign word_ready = !abort && !tmo_hit && ((state == S_FETCH) || reload);
    assign accept     = word_ready && word_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            shreg       <= '0;
            bitcnt      <= '0;
            words_left  <= '0;
            drain_cnt   <= '0;
            det_clr     <= 1'b0;
            det_len     <= '0;
            det_pattern <= '0;
            match_count <= '0;
            cfg_err     <= 1'b0;
`ifdef SEQDET_CTRL_TIMEOUT_EN
            tmo_cnt     <= '0;
            timeout     <= 1'b0;
`endif
        end else begin
            det_clr <= 1'b0;
            if (busy && det_match && (match_count != '1))
                match_count <= match_count + CNT_W'(1);

            if (abort && busy) begin
                state   <= S_IDLE;
                det_clr <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cfg_we) begin
                            det_len     <= len_in;
                            det_pattern <= cfg_pattern;
                            cfg_err     <= 1'b0;
                        end
                        if (start) begin
                            if (eff_len == 5'd0) begin
                                cfg_err <= 1'b1;
                            end else begin
                                state      <= S_CLEAR;
                                det_clr    <= 1'b1;
                                words_left <= num_words;
`ifdef SEQDET_CTRL_TIMEOUT_EN
                                tmo_cnt    <= '0;
                                timeout    <= 1'b0;
`endif
                            end
                        end
                    end
                    S_CLEAR: begin
                        match_count <= '0;
                        state       <= (words_left == 8'd0) ? S_DONE : S_FETCH;
                    end
                    S_FETCH: begin
                        if (tmo_hit) begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
`ifdef SEQDET_CTRL_TIMEOUT_EN
                            timeout   <= 1'b1;
`endif
                        end else if (accept) begin
                            shreg  <= word_data;
                            bitcnt <= '0;
                            state  <= S_SHIFT;
`ifdef SEQDET_CTRL_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                        end else begin
`ifdef SEQDET_CTRL_TIMEOUT_EN
                            tmo_cnt <= tmo_cnt + TMW'(1);
`endif
                        end
                    end
                    S_SHIFT: begin
                        shreg  <= {shreg[DATA_W-2:0], 1'b0};
                        bitcnt <= bitcnt + BCW'(1);
                        if (last_bit) begin
                            words_left <= words_left - 8'd1;
                            if (reload) begin
                                // Reload on the last bit keeps det_en contiguous across words.
                                if (accept) begin
                                    shreg  <= word_data;
                                    bitcnt <= '0;
`ifdef SEQDET_CTRL_TIMEOUT_EN
                                    tmo_cnt <= '0;
`endif
                                end else begin
                                    state <= S_FETCH;
`ifdef SEQDET_CTRL_TIMEOUT_EN
                                    tmo_cnt <= tmo_cnt + TMW'(1);
`endif
                                end
                            end else begin
                                state     <= S_DRAIN;
                                drain_cnt <= '0;
                            end
                        end
                    end
                    S_DRAIN: begin
                        // Wait out the detector latency so the final match is counted.
                        if (drain_cnt == DLW'(DET_LAT - 1))
                            state <= S_DONE;
                        else
                            drain_cnt <= drain_cnt + DLW'(1);
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seqdet_ctrl.sv
// Scoreboard bench for seqdet_ctrl with a behavioural detector (latency 1).
module tb_seqdet_ctrl;
    localparam int DATA_W = 8, MAX_LEN = 16, DET_LAT = 1, CNT_W = 8;

    logic clk = 1'b0, rst = 1'b1;
    logic cfg_we = 0, start = 0, abort = 0, word_valid = 0;
    logic [4:0] cfg_len = 0;
    logic [MAX_LEN-1:0] cfg_pattern = 0;
    logic [7:0] num_words = 0;
    logic [DATA_W-1:0] word_data = 0;
    logic word_ready, det_bit, det_en, det_clr, det_match, busy, done, cfg_err;
    logic [4:0] det_len;
    logic [MAX_LEN-1:0] det_pattern;
    logic [CNT_W-1:0] match_count;
`ifdef SEQDET_CTRL_TIMEOUT_EN
    logic timeout;
`endif

    always #5 clk = ~clk;

    seqdet_ctrl #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .DET_LAT(DET_LAT), .CNT_W(CNT_W)
`ifdef SEQDET_CTRL_TIMEOUT_EN
        , .TIMEOUT(10)
`endif
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_len(cfg_len), .cfg_pattern(cfg_pattern),
        .start(start), .num_words(num_words), .abort(abort), .word_valid(word_valid),
        .word_data(word_data), .word_ready(word_ready), .det_bit(det_bit), .det_en(det_en),
        .det_clr(det_clr), .det_len(det_len), .det_pattern(det_pattern), .det_match(det_match),
        .match_count(match_count), .busy(busy), .done(done),
`ifdef SEQDET_CTRL_TIMEOUT_EN
        .timeout(timeout),
`endif
        .cfg_err(cfg_err)
    );

    int nvec = 0, nerr = 0;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic hit(input logic [15:0] h, input logic [4:0] len, input logic [15:0] pat);
        logic [15:0] m;
        m = (len >= 5'd16) ? 16'hFFFF : ((16'd1 << len) - 16'd1);
        return (len != 0) && (((h ^ pat) & m) == 16'd0);
    endfunction

    // Behavioural detector: one-cycle match latency, history cleared by det_clr.
    logic [15:0] hist;
    logic mdl_match, force_match = 1'b0;
    wire [15:0] nh = {hist[14:0], det_bit};
    always @(posedge clk) begin
        if (rst || det_clr) begin
            hist <= '0;
            mdl_match <= 1'b0;
        end else begin
            mdl_match <= det_en && hit(nh, det_len, det_pattern);
            if (det_en) hist <= nh;
        end
    end
    assign det_match = mdl_match | force_match;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: expected serial bits are queued when a word is handed over.
    bit expq[$];
    bit stream[$];
    logic [7:0] wdat[$];
    int wgap[$];
    int en_cnt = 0, first_en = 0, last_en = 0, rdy_cnt = 0, done_cnt = 0, done_cyc = 0;

    always @(negedge clk) begin
        if (det_en) begin
            if (en_cnt == 0) first_en = cyc;
            last_en = cyc;
            en_cnt++;
            if (expq.size() == 0) check("det_bit_extra", {31'd0, det_en}, 32'd0);
            else check("det_bit", {31'd0, det_bit}, {31'd0, expq.pop_front()});
        end
        if (word_ready) rdy_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        bit took;
        logic [7:0] w;
        forever begin
            @(negedge clk);
            took = word_valid && word_ready;
            @(posedge clk);
            #1;
            if (took && wdat.size() > 0) begin
                w = wdat.pop_front();
                void'(wgap.pop_front());
                for (int b = 7; b >= 0; b--) expq.push_back(w[b]);
            end
            if (wdat.size() == 0) word_valid = 0;
            else if (wgap[0] > 0) begin
                wgap[0] = wgap[0] - 1;
                word_valid = 0;
            end else begin
                word_valid = 1;
                word_data = wdat[0];
            end
        end
    end

    function automatic int ref_matches(input logic [4:0] len, input logic [15:0] pat);
        logic [15:0] h = '0;
        int n = 0;
        foreach (stream[i]) begin
            h = {h[14:0], stream[i]};
            if (i >= int'(len) - 1 && hit(h, len, pat)) n++;
        end
        return n;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_cfg(input logic [4:0] len, input logic [15:0] pat);
        cfg_len = len; cfg_pattern = pat; cfg_we = 1;
        tick(1);
        cfg_we = 0;
    endtask

    task automatic push_word(input logic [7:0] d, input int gap);
        wdat.push_back(d);
        wgap.push_back(gap);
        for (int b = 7; b >= 0; b--) stream.push_back(d[b]);
    endtask

    task automatic run_frame(input int nw, input int exp_lat, input int budget, input string tag);
        int d0, c0;
        en_cnt = 0; rdy_cnt = 0;
        d0 = done_cnt; c0 = cyc;
        num_words = 8'(nw); start = 1;
        tick(1);
        start = 0;
        for (int k = 0; k < budget && done_cnt == d0; k++) tick(1);
        check({tag, "_done_lat"}, (done_cnt == d0) ? 32'hFFFFFFFF : 32'(done_cyc - c0), 32'(exp_lat));
    endtask

    initial begin
        int c0, d0;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, d0;
        tick(3);
        rst = 0;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_ready", {31'd0, word_ready}, 0);
        check("rst_en", {31'd0, det_en}, 0);
        check("rst_clr", {31'd0, det_clr}, 0);
        check("rst_len", {27'd0, det_len}, 0);
        check("rst_pat", {16'd0, det_pattern}, 0);
        check("rst_cnt", {24'd0, match_count}, 0);
        check("rst_cfg_err", {31'd0, cfg_err}, 0);
`ifdef SEQDET_CTRL_TIMEOUT_EN
        check("rst_timeout", {31'd0, timeout}, 0);
`endif

        do_cfg(5'd4, 16'h000B);
        check("cfg_len", {27'd0, det_len}, 4);
        check("cfg_pat", {16'd0, det_pattern}, 32'h000B);

        // Single word, pattern 1011 over 10111011 -> two matches.
        stream.delete(); push_word(8'b10111011, 0);
        run_frame(1, 12, 40, "single");
        check("single_en", en_cnt, 8);
        check("single_cnt", {24'd0, match_count}, 2);
        check("single_busy", {31'd0, busy}, 0);

        // Back-to-back words with valid always high.
        do_cfg(5'd3, 16'h0005);
        stream.delete(); push_word(8'hA5, 0); push_word(8'h5A, 0); push_word(8'hFF, 0);
        run_frame(3, 28, 80, "b2b");
        check("b2b_en", en_cnt, 24);
        check("b2b_span", 32'(last_en - first_en + 1), 24);
        check("b2b_ready", rdy_cnt, 3);
        check("b2b_cnt", {24'd0, match_count}, 32'(ref_matches(5'd3, 16'h0005)));

        // Stall of 5 cycles between words; 1100 straddles the boundary.
        do_cfg(5'd4, 16'h000C);
        stream.delete(); push_word(8'h03, 0); push_word(8'h00, 12);
        run_frame(2, 25, 80, "stall");
        check("stall_en", en_cnt, 16);
        check("stall_span", 32'(last_en - first_en + 1), 21);
        check("stall_cnt", {24'd0, match_count}, 32'(ref_matches(5'd4, 16'h000C)));

        // Abort during bit 3; one match (pattern 10) already counted.
        do_cfg(5'd2, 16'h0002);
        stream.delete(); push_word(8'hBB, 0);
        d0 = done_cnt; num_words = 1; start = 1;
        tick(1);
        start = 0;
        tick(5);
        abort = 1;
        tick(1);
        abort = 0;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_clr", {31'd0, det_clr}, 1);
        check("abort_cnt", {24'd0, match_count}, 1);
        tick(5);
        check("abort_nodone", done_cnt - d0, 0);
        check("abort_cnt_hold", {24'd0, match_count}, 1);
        expq.delete(); wdat.delete(); wgap.delete();

        // Empty frame: CLEAR then DONE, count cleared.
        run_frame(0, 2, 10, "empty");
        check("empty_cnt", {24'd0, match_count}, 0);

        // Zero length refuses start.
        do_cfg(5'd0, 16'h0000);
        num_words = 1; start = 1;
        tick(1);
        start = 0;
        check("zlen_err", {31'd0, cfg_err}, 1);
        check("zlen_busy", {31'd0, busy}, 0);
        do_cfg(5'd4, 16'h000B);
        check("cfg_err_clr", {31'd0, cfg_err}, 0);

        // Config and start together: the new zero length wins.
        cfg_len = 0; cfg_we = 1; start = 1;
        tick(1);
        cfg_we = 0; start = 0;
        check("same_err", {31'd0, cfg_err}, 1);
        check("same_busy", {31'd0, busy}, 0);
        do_cfg(5'd20, 16'hABCD);
        check("clamp_len", {27'd0, det_len}, 16);
        check("clamp_pat", {16'd0, det_pattern}, 32'hABCD);

        // Long frame with forced matches: saturation and ignored mid-frame config.
        do_cfg(5'd4, 16'h000B);
        stream.delete();
        for (int i = 0; i < 40; i++) push_word(8'h00, 0);
        d0 = done_cnt; num_words = 40; start = 1;
        tick(1);
        start = 0; force_match = 1;
        tick(10);
        cfg_len = 7; cfg_we = 1;
        tick(1);
        cfg_we = 0;
        check("busy_cfg_ignored", {27'd0, det_len}, 4);
        tick(300);
        force_match = 0;
        check("sat_cnt", {24'd0, match_count}, 255);
        for (int k = 0; k < 100 && done_cnt == d0; k++) tick(1);
        check("sat_done", done_cnt - d0, 1);

`ifdef SEQDET_CTRL_TIMEOUT_EN
        stream.delete();
        run_frame(1, 14, 40, "tmo");
        check("tmo_flag", {31'd0, timeout}, 1);
        run_frame(0, 2, 10, "tmo_clr");
        check("tmo_flag_clr", {31'd0, timeout}, 0);
`endif

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/seqdet_ctrl.md
Name: seqdet_ctrl

Overview:
Sequencing controller for the programmable serial sequence detector.
- Holds the detector configuration: pattern and length.
- Accepts a frame of parallel data words over a valid/ready interface and serialises them MSB-first onto the detector's one-bit input, with a per-bit enable.
- Counts detector match pulses for the frame and reports completion.
- Sits between the host-side word source and the detector core.

Parameters:
- DATA_W, 8: width of an incoming data word; bits are serialised MSB-first.
- MAX_LEN, 16: maximum pattern length in bits; also the width of cfg_pattern and det_pattern.
- DET_LAT, 1: cycles from a det_en bit to its resulting det_match. Sets the drain length.
- CNT_W, 8: width of match_count. The count saturates at all-ones.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous reset, active-high.
- cfg_we  in  1  configuration write strobe; honoured only in IDLE.
- cfg_len  in  5  pattern length in bits.
- cfg_pattern  in  MAX_LEN  pattern; LSB-aligned, and bit 0 is the last bit received.
- start  in  1  begin a frame; sampled only in IDLE.
- num_words  in  8  number of words in the frame; latched on an accepted start.
- abort  in  1  terminate the frame.
- word_valid  in  1  source has a word.
- word_data  in  DATA_W  word payload.
- word_ready  out  1  controller accepts the word this cycle.
- det_bit  out  1  serial bit to the detector.
- det_en  out  1  detector advances one bit this cycle.
- det_clr  out  1  one-cycle clear of the detector's shift history.
- det_len  out  5  registered pattern length to the detector.
- det_pattern  out  MAX_LEN  registered pattern to the detector.
- det_match  in  1  match pulse from the detector.
- match_count  out  CNT_W  matches counted in the current or last frame.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at normal frame end.
- cfg_err  out  1  sticky flag: a start was refused because det_len==0.

Behaviour:
- Reset values: all outputs 0, including det_len, det_pattern and match_count. State is IDLE.
- Configuration:
  - On cfg_we in IDLE: det_len <= min(cfg_len, MAX_LEN) and det_pattern <= cfg_pattern.
  - cfg_we in any other state is ignored.
  - cfg_err clears on any accepted cfg_we.
- State IDLE:
  - start with det_len==0 sets cfg_err and the FSM stays in IDLE.
  - Otherwise start moves to CLEAR and latches words_left <= num_words.
- State CLEAR (exactly 1 cycle):
  - det_clr=1 and match_count <= 0.
  - Next state is DONE if words_left==0, else FETCH.
- State FETCH:
  - word_ready=1 and det_en=0.
  - On word_valid: shreg <= word_data, bitcnt <= 0, next state SHIFT.
  - Without word_valid the FSM stalls indefinitely and det_en stays 0.
- State SHIFT:
  - det_en=1 and det_bit=shreg[DATA_W-1]; shreg shifts left and bitcnt increments.
  - On the last bit (bitcnt==DATA_W-1), words_left decrements. Then:
    - If words_left>1, word_ready=1 this cycle. With word_valid, the new word loads and SHIFT continues with no bubble. Without it, the next state is FETCH.
    - If words_left==1, the next state is DRAIN.
- State DRAIN:
  - Lasts DET_LAT cycles with det_en=0, then moves to DONE.
- State DONE:
  - done=1 for one cycle, then IDLE.
- Match counting:
  - Every det_match=1 seen while busy increments match_count, saturating at 2^CNT_W-1.
  - det_match outside busy is ignored.
  - match_count holds its value in IDLE.
- Abort (priority over all transitions except rst):
  - abort while busy forces IDLE next cycle and asserts det_clr that cycle.
  - No done pulse; match_count is retained.
  - A word offered in the same cycle is not accepted (word_ready=0).
- Simultaneous start and cfg_we in IDLE: the config is written first. The start is evaluated against the new det_len.
- rst mid-frame returns every register to its reset value on the next edge.
- word_ready is never asserted in IDLE, CLEAR, DRAIN or DONE.

Optional Feature:
SEQDET_CTRL_TIMEOUT_EN
- When defined:
  - Adds parameter TIMEOUT (default 255) and output timeout (1 bit, reset 0).
  - A counter runs during FETCH stalls and also during the last SHIFT bit when a reload is expected but word_valid is low.
  - If it reaches TIMEOUT, the FSM moves to DRAIN and then DONE, and timeout is set. timeout is sticky until the next accepted start.
  - The counter clears whenever a word is accepted.
- When undefined: no counter, no timeout port, and stalls are unbounded.

Test Plan:
- Config and single word: cfg_len=4, cfg_pattern=16'h000B, num_words=1, word 8'b10111011, with a behavioural detector model (DET_LAT=1) -> det_bit sequence 1,0,1,1,1,0,1,1 on 8 consecutive det_en cycles; match_count=2; done pulses 1+1+1+8+1 cycles after start.
- Back-to-back: num_words=3, word_valid held high -> 24 contiguous det_en cycles with no bubble; word_ready high only in FETCH and the last-bit cycles.
- Stall: num_words=2, second word delayed 5 cycles -> det_en=0 for those cycles; bit order preserved; match across the word boundary still counted.
- Abort: abort in SHIFT at bit 3 -> next cycle busy=0, det_clr=1, no done; match_count holds its pre-abort value.
- Edge cases: start with cfg_len=0 -> cfg_err=1 and busy stays 0. num_words=0 -> CLEAR then DONE, match_count=0. cfg_len=20 -> det_len=16. 300 forced det_match pulses -> match_count=255.
- With SEQDET_CTRL_TIMEOUT_EN and TIMEOUT=10: word never offered -> timeout=1 and done pulses 10+DET_LAT+1 cycles after FETCH entry.
